// File: rtl/mesm6_memctl.sv
// mesm6_memctl -- memory controller behind the MESM-6 core.
//
// Serves the instruction bus (ibus) and data bus (dbus) from one single-port,
// variable-latency 48-bit word memory. When a fetch and a data access are
// requested in the same cycle, the data access runs first. Both done pulses
// are then issued together so the core sees a single completion. Returned
// words are registered and held until the next read result on that bus.
// With ZERO_WORD=1, word 0 reads as zero and ignores writes, and no memory
// cycle is issued for it.
//
// Ports
//   clk, reset            rising-edge clock, synchronous active-high reset
//   ibus_fetch/addr       instruction fetch request (level) and word address
//   ibus_input/done       registered instruction word, one-cycle completion
//   dbus_read/write       data request (level); both high means write
//   dbus_addr/wdata       data word address and write data
//   dbus_input/done       registered data word, one-cycle completion
//   mem_req/we/addr/wdata memory cycle request, held until mem_ack
//   mem_rdata/ack         memory read data, valid with the one-cycle mem_ack

module mesm6_memctl #(
   parameter bit ZERO_WORD = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ibus_fetch,
   input  logic [14:0] ibus_addr,
   output logic [47:0] ibus_input,
   output logic        ibus_done,
   input  logic        dbus_read,
   input  logic        dbus_write,
   input  logic [14:0] dbus_addr,
   input  logic [47:0] dbus_wdata,
   output logic [47:0] dbus_input,
   output logic        dbus_done,
   output logic        mem_req,
   output logic        mem_we,
   output logic [14:0] mem_addr,
   output logic [47:0] mem_wdata,
   input  logic [47:0] mem_rdata,
   input  logic        mem_ack
);

   // state   | meaning
   // IDLE    | sample core requests, latch addresses / write data
   // DACC    | data memory cycle in flight, waiting for mem_ack
   // IACC    | instruction memory cycle in flight, waiting for mem_ack
   // DONE    | pulse done(s) for the sampled buses, ignore requests
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_DACC = 2'd1;
   localparam logic [1:0] ST_IACC = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   logic [1:0]  state;
   logic        pend_i;
   logic        pend_d;
   logic [14:0] iaddr_lat;

   logic d_req;
   logic d_zero;
   logic i_zero;
   logic i_lat_zero;

   assign d_req      = dbus_read | dbus_write;
   assign d_zero     = ZERO_WORD && (dbus_addr == 15'd0);
   assign i_zero     = ZERO_WORD && (ibus_addr == 15'd0);
   assign i_lat_zero = ZERO_WORD && (iaddr_lat == 15'd0);

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         pend_i     <= 1'b0;
         pend_d     <= 1'b0;
         iaddr_lat  <= 15'd0;
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= 15'd0;
         mem_wdata  <= 48'd0;
         ibus_input <= 48'd0;
         dbus_input <= 48'd0;
         ibus_done  <= 1'b0;
         dbus_done  <= 1'b0;
      end else begin
         ibus_done <= 1'b0;
         dbus_done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (d_req) begin
                  pend_d    <= 1'b1;
                  pend_i    <= ibus_fetch;
                  iaddr_lat <= ibus_addr;
                  if (!d_zero) begin
                     state     <= ST_DACC;
                     mem_req   <= 1'b1;
                     mem_we    <= dbus_write;
                     mem_addr  <= dbus_addr;
                     mem_wdata <= dbus_wdata;
                  end else begin
                     // Hardwired word 0: the data half completes with no
                     // memory cycle; a write is simply dropped.
                     if (!dbus_write)
                        dbus_input <= 48'd0;
                     if (ibus_fetch && !i_zero) begin
                        state    <= ST_IACC;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= ibus_addr;
                     end else begin
                        if (ibus_fetch)
                           ibus_input <= 48'd0;
                        state     <= ST_DONE;
                        dbus_done <= 1'b1;
                        ibus_done <= ibus_fetch;
                     end
                  end
               end else if (ibus_fetch) begin
                  pend_d    <= 1'b0;
                  pend_i    <= 1'b1;
                  iaddr_lat <= ibus_addr;
                  if (!i_zero) begin
                     state    <= ST_IACC;
                     mem_req  <= 1'b1;
                     mem_we   <= 1'b0;
                     mem_addr <= ibus_addr;
                  end else begin
                     ibus_input <= 48'd0;
                     state      <= ST_DONE;
                     ibus_done  <= 1'b1;
                  end
               end
            end

            ST_DACC: begin
               if (mem_ack) begin
                  if (!mem_we)
                     dbus_input <= mem_rdata;
                  if (pend_i && !i_lat_zero) begin
                     // Chain straight into the fetch; mem_req stays high.
                     state    <= ST_IACC;
                     mem_we   <= 1'b0;
                     mem_addr <= iaddr_lat;
                  end else begin
                     if (pend_i)
                        ibus_input <= 48'd0;
                     state     <= ST_DONE;
                     mem_req   <= 1'b0;
                     mem_we    <= 1'b0;
                     dbus_done <= 1'b1;
                     ibus_done <= pend_i;
                  end
               end
            end

            ST_IACC: begin
               if (mem_ack) begin
                  ibus_input <= mem_rdata;
                  state      <= ST_DONE;
                  mem_req    <= 1'b0;
                  mem_we     <= 1'b0;
                  ibus_done  <= 1'b1;
                  dbus_done  <= pend_d;
               end
            end

            ST_DONE: begin
               state <= ST_IDLE;
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mesm6_memctl.sv
// Testbench for mesm6_memctl: randomized-latency memory responder plus a
// transaction-level reference model (word array, latency arithmetic).
module tb_mesm6_memctl;

   typedef struct {
      logic        we;
      logic [14:0] addr;
      logic [47:0] wdata;
   } acc_t;

   logic        clk;
   logic        reset;
   logic        ibus_fetch;
   logic [14:0] ibus_addr;
   logic [47:0] ibus_input;
   logic        ibus_done;
   logic        dbus_read;
   logic        dbus_write;
   logic [14:0] dbus_addr;
   logic [47:0] dbus_wdata;
   logic [47:0] dbus_input;
   logic        dbus_done;
   logic        mem_req;
   logic        mem_we;
   logic [14:0] mem_addr;
   logic [47:0] mem_wdata;
   logic [47:0] mem_rdata;
   logic        mem_ack;

   // second instance with ordinary word 0
   logic        ibus_fetch0;
   logic [14:0] ibus_addr0;
   logic [47:0] ibus_input0;
   logic        ibus_done0;
   logic        dbus_read0;
   logic        dbus_write0;
   logic [14:0] dbus_addr0;
   logic [47:0] dbus_wdata0;
   logic [47:0] dbus_input0;
   logic        dbus_done0;
   logic        mem_req0;
   logic        mem_we0;
   logic [14:0] mem_addr0;
   logic [47:0] mem_wdata0;
   logic [47:0] mem_rdata0;
   logic        mem_ack0;

   int vectors;
   int miscompares;

   // responder state
   logic [47:0] ram     [0:32767];
   logic        written [0:32767];
   int          wait_q[$];
   acc_t        acc_q[$];
   int          wcnt;
   int          w_now;
   logic        inject_ack;

   // reference model state
   logic [47:0] ref_mem [0:32767];
   logic [47:0] exp_ibus;
   logic [47:0] exp_dbus;

   mesm6_memctl #(.ZERO_WORD(1'b1)) dut (
      .clk(clk), .reset(reset),
      .ibus_fetch(ibus_fetch), .ibus_addr(ibus_addr),
      .ibus_input(ibus_input), .ibus_done(ibus_done),
      .dbus_read(dbus_read), .dbus_write(dbus_write),
      .dbus_addr(dbus_addr), .dbus_wdata(dbus_wdata),
      .dbus_input(dbus_input), .dbus_done(dbus_done),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
   );

   mesm6_memctl #(.ZERO_WORD(1'b0)) dut0 (
      .clk(clk), .reset(reset),
      .ibus_fetch(ibus_fetch0), .ibus_addr(ibus_addr0),
      .ibus_input(ibus_input0), .ibus_done(ibus_done0),
      .dbus_read(dbus_read0), .dbus_write(dbus_write0),
      .dbus_addr(dbus_addr0), .dbus_wdata(dbus_wdata0),
      .dbus_input(dbus_input0), .dbus_done(dbus_done0),
      .mem_req(mem_req0), .mem_we(mem_we0), .mem_addr(mem_addr0),
      .mem_wdata(mem_wdata0), .mem_rdata(mem_rdata0), .mem_ack(mem_ack0)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [47:0] init_word(input logic [14:0] a);
      return {a, 2'b10, ~a, 1'b0, a ^ 15'h2AAA};
   endfunction

   // Memory: pops a wait count per access, acks after that many extra cycles.
   always @(negedge clk) begin
      mem_ack <= inject_ack;
      if (reset || !mem_req) begin
         wcnt <= -1;
      end else begin
         if (wcnt < 0) begin
            if (wait_q.size() > 0) w_now = wait_q.pop_front();
            else w_now = 0;
         end else begin
            w_now = wcnt;
         end
         if (w_now == 0) begin
            mem_ack   <= 1'b1;
            mem_rdata <= written[mem_addr] ? ram[mem_addr] : init_word(mem_addr);
            if (mem_we) begin
               ram[mem_addr]     <= mem_wdata;
               written[mem_addr] <= 1'b1;
            end
            acc_q.push_back('{mem_we, mem_addr, mem_wdata});
            wcnt <= -1;
         end else begin
            wcnt <= w_now - 1;
         end
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One core transaction; expectations come from the word array and the
   // latency rule: done cycle = 1 + sum over real memory cycles of (1 + waits).
   task automatic txn(input logic rd, input logic wr, input logic fe,
                      input logic [14:0] da, input logic [14:0] ia,
                      input logic [47:0] wd, input int dw, input int iw,
                      input string tag);
      logic d, dz, iz;
      int   lat, c;
      acc_t e;
      acc_t exp_q[$];
      d  = rd | wr;
      dz = d && (da == 15'd0);
      iz = fe && (ia == 15'd0);
      wait_q.delete();
      acc_q.delete();
      lat = 1;
      if (d && !dz) begin
         lat += 1 + dw;
         wait_q.push_back(dw);
         e.we = wr; e.addr = da; e.wdata = wd;
         exp_q.push_back(e);
      end
      if (fe && !iz) begin
         lat += 1 + iw;
         wait_q.push_back(iw);
         e.we = 1'b0; e.addr = ia; e.wdata = 48'd0;
         exp_q.push_back(e);
      end
      if (d && wr && !dz) ref_mem[da] = wd;
      if (d && !wr) exp_dbus = dz ? 48'd0 : ref_mem[da];
      if (fe) exp_ibus = iz ? 48'd0 : ref_mem[ia];

      dbus_read = rd; dbus_write = wr; ibus_fetch = fe;
      dbus_addr = da; ibus_addr = ia; dbus_wdata = wd;
      c = 0;
      do begin
         @(posedge clk); #1;
         c++;
      end while (!(ibus_done || dbus_done) && c < 200);
      dbus_read = 1'b0; dbus_write = 1'b0; ibus_fetch = 1'b0;

      chk({tag, "/latency"}, 64'(c), 64'(lat));
      chk({tag, "/ibus_done"}, 64'(ibus_done), 64'(fe));
      chk({tag, "/dbus_done"}, 64'(dbus_done), 64'(d));
      chk({tag, "/mem_req_off"}, 64'(mem_req), 64'd0);
      chk({tag, "/ibus_input"}, 64'(ibus_input), 64'(exp_ibus));
      chk({tag, "/dbus_input"}, 64'(dbus_input), 64'(exp_dbus));
      chk({tag, "/mem_cycles"}, 64'(acc_q.size()), 64'(exp_q.size()));
      for (int k = 0; k < exp_q.size(); k++) begin
         if (k < acc_q.size()) begin
            chk({tag, "/acc_we"}, 64'(acc_q[k].we), 64'(exp_q[k].we));
            chk({tag, "/acc_addr"}, 64'(acc_q[k].addr), 64'(exp_q[k].addr));
            if (exp_q[k].we)
               chk({tag, "/acc_wdata"}, 64'(acc_q[k].wdata), 64'(exp_q[k].wdata));
         end
      end
      @(posedge clk); #1;
      chk({tag, "/done_width"}, 64'({ibus_done, dbus_done}), 64'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int   pulses, dbl;
      logic prev;
      logic rd, wr, fe;

      vectors = 0; miscompares = 0;
      inject_ack = 1'b0;
      reset = 1'b1;
      ibus_fetch = 0; ibus_addr = 0; dbus_read = 0; dbus_write = 0;
      dbus_addr = 0; dbus_wdata = 0;
      ibus_fetch0 = 0; ibus_addr0 = 0; dbus_read0 = 0; dbus_write0 = 0;
      dbus_addr0 = 0; dbus_wdata0 = 0; mem_rdata0 = 0; mem_ack0 = 0;
      for (int i = 0; i < 32768; i++) ref_mem[i] = init_word(15'(i));
      exp_ibus = 48'd0; exp_dbus = 48'd0;

      repeat (3) @(posedge clk);
      #1;
      chk("rst/mem_req", 64'(mem_req), 64'd0);
      chk("rst/mem_we", 64'(mem_we), 64'd0);
      chk("rst/mem_addr", 64'(mem_addr), 64'd0);
      chk("rst/mem_wdata", 64'(mem_wdata), 64'd0);
      chk("rst/dones", 64'({ibus_done, dbus_done}), 64'd0);
      chk("rst/ibus_input", 64'(ibus_input), 64'd0);
      chk("rst/dbus_input", 64'(dbus_input), 64'd0);
      reset = 1'b0;
      @(posedge clk); #1;

      // fetch 0o100 with 2 memory wait cycles, after writing the word there
      txn(0, 1, 0, 15'o00100, 0, 48'h123456789ABC, 0, 0, "wr100");
      txn(0, 0, 1, 0, 15'o00100, 48'd0, 0, 2, "fetch100");
      // simultaneous write 5 and fetch 6, zero-wait
      txn(0, 1, 1, 15'd5, 15'd6, 48'hFFFF00000001, 0, 0, "dual_wr_fetch");
      txn(1, 0, 0, 15'd5, 0, 48'd0, 1, 0, "rd5");
      // word 0 behaviour
      txn(1, 0, 0, 15'd0, 0, 48'd0, 0, 0, "rd0");
      txn(0, 1, 0, 15'd0, 0, 48'hDEADBEEF0001, 0, 0, "wr0");
      txn(1, 0, 0, 15'd0, 0, 48'd0, 0, 0, "rd0_again");
      txn(1, 1, 1, 15'd7, 15'd0, 48'h0000CAFE0000, 0, 0, "rdwr_fetch0");
      txn(1, 0, 1, 15'd0, 15'd7, 48'd0, 0, 1, "rd0_fetch7");

      // ALU stall: dbus_read held, zero-wait memory, one access per 3 cycles
      wait_q.delete(); acc_q.delete();
      exp_dbus = ref_mem[2];
      dbus_read = 1'b1; dbus_addr = 15'd2;
      pulses = 0; dbl = 0; prev = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         @(posedge clk); #1;
         if (dbus_done) pulses++;
         if (dbus_done && prev) dbl++;
         prev = dbus_done;
         if (pulses > 0) chk("stall/dbus_input", 64'(dbus_input), 64'(exp_dbus));
         if (k == 12) dbus_read = 1'b0;
      end
      chk("stall/pulses", 64'(pulses), 64'd4);
      chk("stall/double_pulse", 64'(dbl), 64'd0);
      chk("stall/mem_cycles", 64'(acc_q.size()), 64'd4);
      repeat (2) @(posedge clk);
      #1;

      // spurious ack while idle
      inject_ack = 1'b1;
      @(posedge clk); #1;
      inject_ack = 1'b0;
      for (int k = 0; k < 2; k++) begin
         @(posedge clk); #1;
         chk("spur/dones", 64'({ibus_done, dbus_done}), 64'd0);
         chk("spur/mem_req", 64'(mem_req), 64'd0);
         chk("spur/dbus_input", 64'(dbus_input), 64'(exp_dbus));
         chk("spur/ibus_input", 64'(ibus_input), 64'(exp_ibus));
      end

      // reset while the memory is stalling
      wait_q.delete(); acc_q.delete();
      wait_q.push_back(30);
      dbus_read = 1'b1; dbus_addr = 15'd3;
      repeat (2) @(posedge clk);
      #1;
      chk("rstmid/mem_req_before", 64'(mem_req), 64'd1);
      reset = 1'b1; dbus_read = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("rstmid/mem_req", 64'(mem_req), 64'd0);
      chk("rstmid/dones", 64'({ibus_done, dbus_done}), 64'd0);
      chk("rstmid/dbus_input", 64'(dbus_input), 64'd0);
      chk("rstmid/ibus_input", 64'(ibus_input), 64'd0);
      chk("rstmid/mem_addr", 64'(mem_addr), 64'd0);
      exp_dbus = 48'd0; exp_ibus = 48'd0;
      inject_ack = 1'b1;
      @(posedge clk); #1;
      inject_ack = 1'b0;
      for (int k = 0; k < 2; k++) begin
         @(posedge clk); #1;
         chk("rstmid/late_ack_dones", 64'({ibus_done, dbus_done}), 64'd0);
         chk("rstmid/late_ack_req", 64'(mem_req), 64'd0);
      end
      chk("rstmid/mem_cycles", 64'(acc_q.size()), 64'd0);

      // randomized transactions over a small address window
      for (int n = 0; n < 40; n++) begin
         rd = 1'($urandom_range(0, 1));
         wr = 1'($urandom_range(0, 1));
         fe = 1'($urandom_range(0, 1));
         if (!(rd || wr || fe)) fe = 1'b1;
         txn(rd, wr, fe, 15'($urandom_range(0, 7)), 15'($urandom_range(0, 7)),
             48'({$urandom(), $urandom()}), int'($urandom_range(0, 3)),
             int'($urandom_range(0, 3)), "rand");
      end

      // ZERO_WORD=0: address 0 is an ordinary memory word
      dbus_read0 = 1'b1; dbus_addr0 = 15'd0;
      @(posedge clk); #1;
      chk("zw0/mem_req", 64'(mem_req0), 64'd1);
      chk("zw0/mem_addr", 64'(mem_addr0), 64'd0);
      chk("zw0/mem_we", 64'(mem_we0), 64'd0);
      chk("zw0/early_done", 64'(dbus_done0), 64'd0);
      mem_rdata0 = 48'h0BADC0DE1234; mem_ack0 = 1'b1;
      @(posedge clk); #1;
      mem_ack0 = 1'b0; dbus_read0 = 1'b0;
      chk("zw0/dbus_done", 64'(dbus_done0), 64'd1);
      chk("zw0/ibus_done", 64'(ibus_done0), 64'd0);
      chk("zw0/dbus_input", 64'(dbus_input0), 64'h0BADC0DE1234);
      chk("zw0/mem_req_off", 64'(mem_req0), 64'd0);
      chk("zw0/ibus_input", 64'(ibus_input0), 64'd0);
      chk("zw0/mem_wdata", 64'(mem_wdata0), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
